io_reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of enabled D-type flip-flop registers between several write requesters, such as the CPU core, timer and USART. It grants one requester per cycle. During the grant cycle it drives that requester's data onto a shared register data bus and asserts the one-hot write enable of the addressed register. The bank captures the data at the end of the grant cycle. The block sits between the requesters and the I/O register file.

---
 rtl/io_reg_write_arbiter.sv | 107 ++++++++++
 tb/tb_io_reg_write_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io_reg_write_arbiter.sv
// Round-robin write arbiter for a shared bank of I/O registers.
// Grants one requester per cycle and drives its data and a one-hot register
// write enable. A requester is never granted in two consecutive cycles.
module io_reg_write_arbiter #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = 3
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*AW-1:0]      addr,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         gnt,
   output logic [NREGS-1:0]        reg_en,
   output logic [WIDTH-1:0]        reg_d,
   output logic                    addr_err,
   output logic                    busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREGS-1:0] en_q, en_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             err_q, err_d;
   logic [PW-1:0]    ptr_q, ptr_d;

   logic [NREQ-1:0]  elig;
   logic             found;
   logic [PW-1:0]    win;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_data;

   // The previous cycle's grant is exactly the turnaround mask.
   assign elig = req & ~gnt_q;
   assign busy = |elig;

   // Pick the first eligible requester at or above the pointer, else wrap to the lowest.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_addr = '0;
      win_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && elig[i] && (PW'(i) >= ptr_q)) begin
            found    = 1'b1;
            win      = PW'(i);
            win_addr = addr[i*AW +: AW];
            win_data = data[i*WIDTH +: WIDTH];
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && elig[i] && (PW'(i) < ptr_q)) begin
            found    = 1'b1;
            win      = PW'(i);
            win_addr = addr[i*AW +: AW];
            win_data = data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state: grant, decoded write enable, data capture and pointer advance.
   always_comb begin
      gnt_d = '0;
      en_d  = '0;
      err_d = 1'b0;
      d_d   = d_q;
      ptr_d = ptr_q;
      if (found) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_d[i] = (win == PW'(i));
         end
         // Out-of-range addresses match no enable bit and raise addr_err instead.
         for (int unsigned r = 0; r < NREGS; r++) begin
            en_d[r] = (win_addr == AW'(r));
         end
         err_d = (32'(win_addr) >= NREGS);
         d_d   = win_data;
         ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         gnt_q <= '0;
         en_q  <= '0;
         d_q   <= '0;
         err_q <= 1'b0;
         ptr_q <= '0;
      end else begin
         gnt_q <= gnt_d;
         en_q  <= en_d;
         d_q   <= d_d;
         err_q <= err_d;
         ptr_q <= ptr_d;
      end
   end

   assign gnt      = gnt_q;
   assign reg_en   = en_q;
   assign reg_d    = d_q;
   assign addr_err = err_q;

endmodule

// File: tb/tb_io_reg_write_arbiter.sv
// Self-checking bench for io_reg_write_arbiter (NREQ=3, WIDTH=8, NREGS=6, AW=3).
module tb_io_reg_write_arbiter;

   localparam int unsigned NREQ  = 3;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREGS = 6;
   localparam int unsigned AW    = 3;

   logic                  clk = 1'b0;
   logic                  clr_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [NREGS-1:0]      reg_en;
   logic [WIDTH-1:0]      reg_d;
   logic                  addr_err;
   logic                  busy;

   int total = 0;
   int bad   = 0;

   io_reg_write_arbiter #(
      .NREQ (NREQ),
      .WIDTH(WIDTH),
      .NREGS(NREGS),
      .AW   (AW)
   ) dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .req     (req),
      .addr    (addr),
      .data    (data),
      .gnt     (gnt),
      .reg_en  (reg_en),
      .reg_d   (reg_d),
      .addr_err(addr_err),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [8:0]  addr;
      logic [23:0] data;
      logic        busy;
      logic [2:0]  gnt;
      logic [5:0]  en;
      logic [7:0]  d;
      logic        err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check busy before the edge and registered outputs after it.
   task automatic step(input string name, input logic [2:0] r, input logic [8:0] a,
                       input logic [23:0] dt, input logic e_busy, input logic [2:0] e_gnt,
                       input logic [5:0] e_en, input logic [7:0] e_d, input logic e_err);
      req  = r;
      addr = a;
      data = dt;
      #1;
      check({name, ".busy"}, 32'(busy), 32'(e_busy));
      @(posedge clk);
      #1;
      check({name, ".gnt"}, 32'(gnt), 32'(e_gnt));
      check({name, ".reg_en"}, 32'(reg_en), 32'(e_en));
      check({name, ".reg_d"}, 32'(reg_d), 32'(e_d));
      check({name, ".addr_err"}, 32'(addr_err), 32'(e_err));
   endtask

   task automatic do_reset();
      req   = '0;
      addr  = '0;
      data  = '0;
      clr_n = 1'b0;
      @(posedge clk);
      #1;
      check("reset.gnt", 32'(gnt), 32'd0);
      check("reset.reg_en", 32'(reg_en), 32'd0);
      check("reset.reg_d", 32'(reg_d), 32'd0);
      check("reset.addr_err", 32'(addr_err), 32'd0);
      clr_n = 1'b1;
   endtask

   vec_t tbl [7];

   // Reference model state: rotation pointer, previous grant, held data.
   int         m_ptr;
   logic [2:0] m_mask;
   logic [7:0] m_d;

   initial begin
      tbl[0] = '{3'b001, 9'b000_000_101, 24'h0000A5, 1'b1, 3'b001, 6'b100000, 8'hA5, 1'b0};
      tbl[1] = '{3'b000, 9'b000_000_000, 24'h000000, 1'b0, 3'b000, 6'b000000, 8'hA5, 1'b0};
      tbl[2] = '{3'b010, 9'b000_111_000, 24'h003C00, 1'b1, 3'b010, 6'b000000, 8'h3C, 1'b1};
      tbl[3] = '{3'b000, 9'b000_000_000, 24'h000000, 1'b0, 3'b000, 6'b000000, 8'h3C, 1'b0};
      tbl[4] = '{3'b011, 9'b000_100_001, 24'h006655, 1'b1, 3'b001, 6'b000010, 8'h55, 1'b0};
      tbl[5] = '{3'b011, 9'b000_100_001, 24'h006655, 1'b1, 3'b010, 6'b010000, 8'h66, 1'b0};
      tbl[6] = '{3'b000, 9'b000_000_000, 24'h000000, 1'b0, 3'b000, 6'b000000, 8'h66, 1'b0};

      // Single grant, addr error with pointer advance, wrap from pointer 2.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].data, tbl[i].busy,
              tbl[i].gnt, tbl[i].en, tbl[i].d, tbl[i].err);
      end

      // All requesting: strict rotation, then reset while gnt=100.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         logic [2:0] g;
         logic [7:0] dd;
         g  = 3'(1 << (i % 3));
         dd = 8'(8'h11 * ((i % 3) + 1));
         step($sformatf("rot%0d", i), 3'b111, 9'b010_010_010, 24'h332211, 1'b1, g,
              6'b000100, dd, 1'b0);
      end
      clr_n = 1'b0;
      #1;
      check("midrst.gnt", 32'(gnt), 32'd0);
      check("midrst.reg_en", 32'(reg_en), 32'd0);
      check("midrst.reg_d", 32'(reg_d), 32'd0);
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      step("after_rst", 3'b111, 9'b010_010_010, 24'h332211, 1'b1, 3'b001, 6'b000100, 8'h11,
           1'b0);

      // Lone requester held high: granted on alternate cycles only.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         logic on;
         on = (i % 2 == 0);
         step($sformatf("solo%0d", i), 3'b001, 9'b000_000_010, 24'h000077, on, {2'b00, on},
              on ? 6'b000100 : 6'b000000, 8'h77, 1'b0);
      end

      // Random traffic against the reference model.
      do_reset();
      m_ptr  = 0;
      m_mask = '0;
      m_d    = '0;
      for (int n = 0; n < 400; n++) begin
         logic [2:0]  r;
         logic [8:0]  a;
         logic [23:0] dt;
         logic [2:0]  e_gnt;
         logic [5:0]  e_en;
         logic        e_err;
         int          w;
         r  = 3'($urandom_range(0, 7));
         a  = 9'($urandom);
         dt = 24'($urandom);
         w  = -1;
         for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (w < 0 && r[idx] && !m_mask[idx]) w = idx;
         end
         e_gnt = '0;
         e_en  = '0;
         e_err = 1'b0;
         if (w >= 0) begin
            int ad;
            ad       = int'(a[w*3 +: 3]);
            e_gnt[w] = 1'b1;
            if (ad < 6) e_en[ad] = 1'b1;
            else e_err = 1'b1;
            m_d   = dt[w*8 +: 8];
            m_ptr = (w + 1) % 3;
         end
         step($sformatf("rnd%0d", n), r, a, dt, |(r & ~m_mask), e_gnt, e_en, m_d, e_err);
         m_mask = e_gnt;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
